// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared types and constants for the clk_div_gen clock divider.
//   div_state_e : divider control states (HOLD, RUN, RESYNC)
//   DIV_W       : width of the divider phase counter
//   HOLD_CYCLES : cycles spent in HOLD after reset release
//   DEL_MAX     : deepest supported delay for the _D outputs
// ---------------------------------------------------------------------------
package clk_div_pkg;

  localparam int DIV_W       = 3;
  localparam int HOLD_CYCLES = 2;
  localparam int DEL_MAX     = 4;

  // Width of the HOLD cycle counter; never narrower than one bit.
  localparam int HOLD_CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } div_state_e;

  typedef logic [DIV_W-1:0] div_t;

endpackage

// File: rtl/clk_div_gen_delay.sv
// ---------------------------------------------------------------------------
// clk_delay_line
// Fixed-depth shift register: o_data is i_data delayed by DEPTH clk cycles.
// Every stage is cleared by the asynchronous active-low reset.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   i_data : WIDTH-bit input sample
//   o_data : WIDTH-bit sample from DEPTH cycles ago
// ---------------------------------------------------------------------------
module clk_delay_line
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH < 1 || DEPTH > DEL_MAX) begin : g_bad_depth
    $error("clk_delay_line: DEPTH out of range");
  end

  logic [WIDTH-1:0] r_stage [DEPTH];

  // NOTE: this array is a shift register, not a RAM, so it can and must be
  // reset; a block RAM would not get a per-entry reset like this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/clk_div_gen.sv
// ---------------------------------------------------------------------------
// clk_div_gen
// Divides CLK_24M by 2/4/8 from a 3-bit phase counter, with a realign
// handshake that loads a new phase, rising-edge strobes for the /4 and /8
// clocks, and optionally delayed copies of the divided clocks.
//
// Build option: define CLKGEN_DELAY_EN to delay the _D outputs by
// DEL_CYCLES cycles through clk_delay_line; otherwise _D = source.
//
// Ports
//   CLK_24M   : master clock, all registers use its rising edge
//   nRESET    : asynchronous active-low reset
//   SYNC_REQ  : phase realign request
//   SYNC_VAL  : phase loaded into the divider on realign
//   SYNC_ACK  : high for the single RESYNC cycle after a realign
//   CLK_12M/CLK_6M/CLK_3M       : registered DIV[0]/DIV[1]/DIV[2]
//   CE_6M/CE_3M                 : high in the cycle CLK_6M/CLK_3M rose
//   CLK_12M_D/CLK_6M_D/CLK_3M_D : delayed copies of the divided clocks
// ---------------------------------------------------------------------------
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int DEL_CYCLES = 1
) (
  input  logic             CLK_24M,
  input  logic             nRESET,
  input  logic             SYNC_REQ,
  input  logic [DIV_W-1:0] SYNC_VAL,
  output logic             SYNC_ACK,
  output logic             CLK_12M,
  output logic             CLK_6M,
  output logic             CLK_3M,
  output logic             CE_6M,
  output logic             CE_3M,
  output logic             CLK_12M_D,
  output logic             CLK_6M_D,
  output logic             CLK_3M_D
);

  if (DEL_CYCLES < 1 || DEL_CYCLES > DEL_MAX) begin : g_bad_del
    $error("clk_div_gen: DEL_CYCLES out of range");
  end

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);

  div_state_e              r_state;
  div_state_e              w_state_nxt;
  div_t                    r_div;
  div_t                    w_div_nxt;
  logic [HOLD_CNT_W-1:0]   r_hold_cnt;
  logic [HOLD_CNT_W-1:0]   w_hold_cnt_nxt;
  logic                    r_req_pend;
  logic                    w_req_pend_nxt;
  logic                    w_sync_ack;

  logic r_clk_12m, r_clk_6m, r_clk_3m;
  logic r_ce_6m, r_ce_3m;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of block ordering.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      r_state    <= HOLD;
      r_div      <= '0;
      r_hold_cnt <= '0;
      r_req_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_req_pend <= w_req_pend_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_hold_cnt_nxt = r_hold_cnt;
    w_req_pend_nxt = r_req_pend;
    w_sync_ack     = 1'b0;

    case (r_state)
      HOLD: begin
        w_div_nxt = '0;
        // A request arriving before the divider runs is remembered and
        // serviced on the first RUN edge with the SYNC_VAL of that edge.
        if (SYNC_REQ) begin
          w_req_pend_nxt = 1'b1;
        end
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_CNT_W'(1);
        end
      end
      RUN: begin
        if (SYNC_REQ || r_req_pend) begin
          w_state_nxt    = RESYNC;
          w_div_nxt      = SYNC_VAL;
          w_req_pend_nxt = 1'b0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      RESYNC: begin
        // Requests are not sampled here; one still held high is taken on
        // the following RUN edge.
        w_sync_ack  = 1'b1;
        w_div_nxt   = r_div + DIV_W'(1);
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = HOLD;
        w_div_nxt   = '0;
      end
    endcase
  end

  // Divided clocks trail DIV by one cycle. A strobe fires when the next
  // clock value is 1 while the current one is 0, so it lands in the same
  // cycle as the rising edge, including edges caused by a realign.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      r_clk_12m <= 1'b0;
      r_clk_6m  <= 1'b0;
      r_clk_3m  <= 1'b0;
      r_ce_6m   <= 1'b0;
      r_ce_3m   <= 1'b0;
    end else begin
      r_clk_12m <= r_div[0];
      r_clk_6m  <= r_div[1];
      r_clk_3m  <= r_div[2];
      r_ce_6m   <= r_div[1] & ~r_clk_6m;
      r_ce_3m   <= r_div[2] & ~r_clk_3m;
    end
  end

  assign SYNC_ACK = w_sync_ack;
  assign CLK_12M  = r_clk_12m;
  assign CLK_6M   = r_clk_6m;
  assign CLK_3M   = r_clk_3m;
  assign CE_6M    = r_ce_6m;
  assign CE_3M    = r_ce_3m;

`ifdef CLKGEN_DELAY_EN
  logic [2:0] w_del_out;

  clk_delay_line #(
    .WIDTH(3),
    .DEPTH(DEL_CYCLES)
  ) u_delay (
    .clk   (CLK_24M),
    .rst_n (nRESET),
    .i_data({r_clk_3m, r_clk_6m, r_clk_12m}),
    .o_data(w_del_out)
  );

  assign CLK_12M_D = w_del_out[0];
  assign CLK_6M_D  = w_del_out[1];
  assign CLK_3M_D  = w_del_out[2];
`else
  assign CLK_12M_D = r_clk_12m;
  assign CLK_6M_D  = r_clk_6m;
  assign CLK_3M_D  = r_clk_3m;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_div_gen
// Directed bench for clk_div_gen. Each step waits one CLK_24M edge, samples
// 1 time unit later and compares against hand-computed vectors packed as
// {SYNC_ACK, CE_3M, CE_6M, CLK_3M, CLK_6M, CLK_12M}. The _D outputs are
// compared with the expected clock bits delayed by the build's delay.
// ---------------------------------------------------------------------------
module tb_clk_div_gen;

`ifdef CLKGEN_DELAY_EN
  localparam int DLY = 3;
`else
  localparam int DLY = 0;
`endif

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       sync_req = 1'b0;
  logic [2:0] sync_val = 3'd0;

  logic sync_ack, clk_12m, clk_6m, clk_3m, ce_6m, ce_3m;
  logic clk_12m_d, clk_6m_d, clk_3m_d;

  always #5 clk = ~clk;

  clk_div_gen #(
    .DEL_CYCLES(3)
  ) dut (
    .CLK_24M  (clk),
    .nRESET   (rst_n),
    .SYNC_REQ (sync_req),
    .SYNC_VAL (sync_val),
    .SYNC_ACK (sync_ack),
    .CLK_12M  (clk_12m),
    .CLK_6M   (clk_6m),
    .CLK_3M   (clk_3m),
    .CE_6M    (ce_6m),
    .CE_3M    (ce_3m),
    .CLK_12M_D(clk_12m_d),
    .CLK_6M_D (clk_6m_d),
    .CLK_3M_D (clk_3m_d)
  );

  logic [5:0] w_obs;
  logic [2:0] w_obs_d;
  assign w_obs   = {sync_ack, ce_3m, ce_6m, clk_3m, clk_6m, clk_12m};
  assign w_obs_d = {clk_3m_d, clk_6m_d, clk_12m_d};

  int n_total = 0;
  int n_bad   = 0;

  // Expected clock bits of the last few steps, newest at index 0.
  logic [2:0] hist [5];

  // Free-running sequence for edges 1..16 after reset release.
  logic [5:0] free_exp [16] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h0A, 6'h03,
                                6'h14, 6'h05, 6'h0E, 6'h07, 6'h00, 6'h01,
                                6'h0A, 6'h03, 6'h14, 6'h05};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 5; i++) hist[i] = 3'd0;
  endtask

  task automatic step(input string tag, input logic [5:0] exp);
    @(posedge clk);
    #1;
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = exp[2:0];
    check(tag, {26'd0, w_obs}, {26'd0, exp});
    check({tag, "_d"}, {29'd0, w_obs_d}, {29'd0, hist[DLY]});
  endtask

  initial begin
    clear_hist();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst", {26'd0, w_obs}, 32'd0);
    check("rst_d", {29'd0, w_obs_d}, 32'd0);

    // Free run: two HOLD cycles, then /2, /4, /8 and strobes.
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step($sformatf("free%0d", i + 1), free_exp[i]);

    // Realign from DIV=5 to 1.
    sync_req = 1'b1;
    sync_val = 3'd1;
    step("rea_ack", 6'h25);
    sync_req = 1'b0;
    step("rea_100", 6'h01);
    step("rea_n2", 6'h0A);
    step("rea_n3", 6'h03);

    // Realign to 0, then reset while SYNC_ACK is high.
    sync_req = 1'b1;
    sync_val = 3'd0;
    step("rs_ack", 6'h34);
    rst_n = 1'b0;
    #2;
    check("rst_async", {26'd0, w_obs}, 32'd0);
    check("rst_async_d", {29'd0, w_obs_d}, 32'd0);
    clear_hist();
    @(posedge clk);
    #1;
    check("rst_over_req", {26'd0, w_obs}, 32'd0);
    sync_req = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("rearm%0d", i + 1), free_exp[i]);

    // Request during HOLD; SYNC_VAL changes before the first RUN edge.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    clear_hist();
    rst_n    = 1'b1;
    sync_req = 1'b1;
    sync_val = 3'd3;
    step("hold1", 6'h00);
    sync_req = 1'b0;
    sync_val = 3'd6;
    step("hold2", 6'h00);
    step("hold_ack", 6'h20);
    step("hold_ce", 6'h1E);
    step("hold_n5", 6'h07);
    step("hold_n6", 6'h00);
    step("hold_n7", 6'h01);

    // Request held through RESYNC is taken again; these realigns make no
    // new edge on CLK_6M so no strobe follows them.
    sync_req = 1'b1;
    sync_val = 3'd2;
    step("held_ack1", 6'h2A);
    step("held_rsy", 6'h02);
    step("held_ack2", 6'h23);
    sync_req = 1'b0;
    step("held_noce", 6'h02);
    step("held_run", 6'h03);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
